// File: rtl/quad_decoder_pkg.sv
// Shared step codes and default widths for the quadrature decoder.
package quad_decoder_pkg;

    localparam int unsigned QD_WIDTH     = 32;
    localparam int unsigned QD_ERR_WIDTH = 8;

    typedef enum logic [1:0] {
        STEP_NONE = 2'd0,
        STEP_UP   = 2'd1,
        STEP_DN   = 2'd2,
        STEP_ERR  = 2'd3
    } step_e;

endpackage

// File: rtl/quad_decoder_step.sv
// Combinational {A,B} transition decode: previous/current sample to step code.
module quad_step_decode
    import quad_decoder_pkg::*;
(
    input  logic [1:0] prev_ab_i,
    input  logic [1:0] cur_ab_i,
    output step_e      step_o
);

    // A-leading sequence 00 -> 10 -> 11 -> 01 -> 00 counts up
    always_comb begin
        step_o = STEP_NONE;
        case ({prev_ab_i, cur_ab_i})
            4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: step_o = STEP_UP;
            4'b10_00, 4'b11_10, 4'b01_11, 4'b00_01: step_o = STEP_DN;
            4'b00_11, 4'b11_00, 4'b10_01, 4'b01_10: step_o = STEP_ERR;
            default:                                step_o = STEP_NONE;
        endcase
    end

endmodule

// File: rtl/quad_decoder.sv
// x4 quadrature decoder with index latch and saturating error count.
// Optional edge-interval period output when QUAD_DECODER_PERIOD_EN is defined.
module quad_decoder
    import quad_decoder_pkg::*;
#(
    parameter int unsigned WIDTH       = QD_WIDTH,
    parameter int unsigned ERR_WIDTH   = QD_ERR_WIDTH,
    parameter int unsigned INDEX_RESET = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 a,
    input  logic                 b,
    input  logic                 z,
    input  logic                 index_arm,
    input  logic                 index_clr,
    input  logic                 err_clr,
    output logic [WIDTH-1:0]     position,
    output logic [WIDTH-1:0]     index_pos,
    output logic                 index_seen,
    output logic [ERR_WIDTH-1:0] err_cnt
`ifdef QUAD_DECODER_PERIOD_EN
    ,
    output logic [WIDTH-1:0]     period
`endif
);

    logic [2:0]           cur_q, prev_q;
    logic [WIDTH-1:0]     pos_q, pos_d, ipos_q, ipos_d, pos_step;
    logic                 seen_q, seen_d, index_evt;
    logic [ERR_WIDTH-1:0] err_q, err_d;
    step_e                step;

    quad_step_decode u_step (
        .prev_ab_i (prev_q[2:1]),
        .cur_ab_i  (cur_q[2:1]),
        .step_o    (step)
    );

    assign index_evt = index_arm & cur_q[0] & ~prev_q[0];

    always_comb begin
        case (step)
            STEP_UP: pos_step = pos_q + WIDTH'(1);
            STEP_DN: pos_step = pos_q - WIDTH'(1);
            default: pos_step = pos_q;
        endcase

        pos_d  = pos_step;
        ipos_d = ipos_q;
        seen_d = seen_q;
        if (index_evt) begin
            // index_pos always records the post-step value, even when the counter is zeroed
            ipos_d = pos_step;
            seen_d = 1'b1;
            if (INDEX_RESET != 0) pos_d = '0;
        end else if (index_clr) begin
            seen_d = 1'b0;
        end

        err_d = err_q;
        if (err_clr) begin
            err_d = (step == STEP_ERR) ? ERR_WIDTH'(1) : '0;
        end else if (step == STEP_ERR && err_q != '1) begin
            err_d = err_q + ERR_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_q  <= '0;
            prev_q <= '0;
            pos_q  <= '0;
            ipos_q <= '0;
            seen_q <= 1'b0;
            err_q  <= '0;
        end else begin
            cur_q  <= {a, b, z};
            prev_q <= cur_q;
            pos_q  <= pos_d;
            ipos_q <= ipos_d;
            seen_q <= seen_d;
            err_q  <= err_d;
        end
    end

    assign position   = pos_q;
    assign index_pos  = ipos_q;
    assign index_seen = seen_q;
    assign err_cnt    = err_q;

`ifdef QUAD_DECODER_PERIOD_EN
    logic [WIDTH-1:0] ivl_q, ivl_d, per_q, per_d;

    // The saturated increment doubles as "interval + 1" captured on a legal step
    always_comb begin
        ivl_d = (ivl_q == '1) ? ivl_q : ivl_q + WIDTH'(1);
        per_d = per_q;
        if (step == STEP_UP || step == STEP_DN) begin
            per_d = ivl_d;
            ivl_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ivl_q <= '0;
            per_q <= '1;
        end else begin
            ivl_q <= ivl_d;
            per_q <= per_d;
        end
    end

    assign period = per_q;
`endif

endmodule

// File: tb/tb_quad_decoder.sv
// Self-checking bench for quad_decoder: directed steps plus random motion vs a phase-arithmetic model.
module tb_quad_decoder;

    localparam int W  = 8;
    localparam int EW = 2;

    logic clk = 1'b0;
    logic rst_n, a, b, z, index_arm, index_clr, err_clr;
    logic [W-1:0]  pos0, ipos0, pos1, ipos1;
    logic          seen0, seen1;
    logic [EW-1:0] err0, err1;
`ifdef QUAD_DECODER_PERIOD_EN
    logic [W-1:0]  per0, per1;
`endif

    always #5 clk = ~clk;

    quad_decoder #(.WIDTH(W), .ERR_WIDTH(EW), .INDEX_RESET(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .z(z),
        .index_arm(index_arm), .index_clr(index_clr), .err_clr(err_clr),
        .position(pos0), .index_pos(ipos0), .index_seen(seen0), .err_cnt(err0)
`ifdef QUAD_DECODER_PERIOD_EN
        , .period(per0)
`endif
    );

    quad_decoder #(.WIDTH(W), .ERR_WIDTH(EW), .INDEX_RESET(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .z(z),
        .index_arm(index_arm), .index_clr(index_clr), .err_clr(err_clr),
        .position(pos1), .index_pos(ipos1), .index_seen(seen1), .err_cnt(err1)
`ifdef QUAD_DECODER_PERIOD_EN
        , .period(per1)
`endif
    );

    int passes = 0;
    int fails  = 0;
    int total  = 0;

    // Reference model state: sampled pins, per-DUT position/index, shared error and timing
    logic [2:0]   m_prev, m_cur;
    logic [W-1:0] m_pos[2];
    logic [W-1:0] m_ipos[2];
    logic         m_seen[2];
    int           m_err, m_cyc, m_last, m_per;
    int           ph;

    function automatic int phase_of(input logic [1:0] ab);
        case (ab)
            2'b00:   return 0;
            2'b10:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    function automatic logic [1:0] ab_of(input int p);
        case (p & 3)
            0:       return 2'b00;
            1:       return 2'b10;
            2:       return 2'b11;
            default: return 2'b01;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("position0",   32'(pos0),  32'(m_pos[0]));
        chk("index_pos0",  32'(ipos0), 32'(m_ipos[0]));
        chk("index_seen0", 32'(seen0), 32'(m_seen[0]));
        chk("err_cnt0",    32'(err0),  m_err);
        chk("position1",   32'(pos1),  32'(m_pos[1]));
        chk("index_pos1",  32'(ipos1), 32'(m_ipos[1]));
        chk("index_seen1", 32'(seen1), 32'(m_seen[1]));
        chk("err_cnt1",    32'(err1),  m_err);
`ifdef QUAD_DECODER_PERIOD_EN
        chk("period0",     32'(per0),  m_per);
        chk("period1",     32'(per1),  m_per);
`endif
    endtask

    task automatic model_reset();
        m_prev = '0;
        m_cur  = '0;
        for (int k = 0; k < 2; k++) begin
            m_pos[k]  = '0;
            m_ipos[k] = '0;
            m_seen[k] = 1'b0;
        end
        m_err  = 0;
        m_cyc  = 0;
        m_last = 0;
        m_per  = 255;
    endtask

    // Applies one clock edge to the model using the current pins and controls
    task automatic model_edge();
        int   d;
        logic ev;
        d  = (phase_of(m_cur[2:1]) - phase_of(m_prev[2:1]) + 4) % 4;
        ev = index_arm && m_cur[0] && !m_prev[0];
        for (int k = 0; k < 2; k++) begin
            logic [W-1:0] post;
            post = m_pos[k] + ((d == 1) ? 8'd1 : (d == 3) ? 8'hFF : 8'd0);
            if (ev) begin
                m_ipos[k] = post;
                m_seen[k] = 1'b1;
                m_pos[k]  = (k == 1) ? 8'd0 : post;
            end else begin
                if (index_clr) m_seen[k] = 1'b0;
                m_pos[k] = post;
            end
        end
        if (d == 2) m_err = err_clr ? 1 : ((m_err < 3) ? m_err + 1 : 3);
        else if (err_clr) m_err = 0;
        m_cyc++;
        if (d == 1 || d == 3) begin
            m_per  = (m_cyc - m_last > 255) ? 255 : m_cyc - m_last;
            m_last = m_cyc;
        end
        m_prev = m_cur;
        m_cur  = {a, b, z};
    endtask

    task automatic tick(input logic arm, input logic iclr, input logic eclr);
        index_arm = arm;
        index_clr = iclr;
        err_clr   = eclr;
        model_edge();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic move(input int dir, input int hold);
        ph = (ph + dir + 4) & 3;
        {a, b} = ab_of(ph);
        repeat (hold) tick(1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset(input logic [2:0] abz);
        @(negedge clk);
        rst_n = 1'b0;
        {a, b, z} = abz;
        index_arm = 1'b0;
        index_clr = 1'b0;
        err_clr   = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        ph = phase_of(abz[2:1]);
    endtask

    initial begin
        rst_n = 1'b0;
        {a, b, z} = 3'b111;
        index_arm = 1'b0;
        index_clr = 1'b0;
        err_clr   = 1'b0;
        ph = 0;
        model_reset();

        // High pins at release compare against the cleared 00 sample
        do_reset(3'b111);
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        chk("rst_err",  32'(err0),  32'd1);
        chk("rst_pos",  32'(pos0),  32'd0);
        chk("rst_seen", 32'(seen0), 32'd0);

        do_reset(3'b000);
        repeat (16) move(1, 3);
        chk("fwd16", 32'(pos0), 32'd16);
        chk("fwd_err", 32'(err0), 32'd0);
        repeat (16) move(-1, 3);
        chk("rev16", 32'(pos0), 32'd0);

        repeat (127) move(1, 1);
        tick(1'b0, 1'b0, 1'b0);
        chk("pre_wrap", 32'(pos0), 32'd127);
        move(1, 2);
        chk("wrap_up", 32'(pos0), 32'h80);
        move(-1, 2);
        chk("wrap_dn", 32'(pos0), 32'd127);

        repeat (4) move(2, 2);
        chk("err_sat", 32'(err0), 32'd3);
        chk("err_pos", 32'(pos0), 32'd127);
        tick(1'b0, 1'b0, 1'b1);
        chk("err_clr", 32'(err0), 32'd0);
        ph = (ph + 2) & 3;
        {a, b} = ab_of(ph);
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b1);
        chk("err_clr_vs_err", 32'(err0), 32'd1);

        do_reset(3'b000);
        repeat (41) move(1, 1);
        tick(1'b0, 1'b0, 1'b0);
        chk("idx_pre", 32'(pos0), 32'd41);
        z = 1'b1;
        ph = (ph + 1) & 3;
        {a, b} = ab_of(ph);
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b1, 1'b0);
        chk("idx_pos0",  32'(ipos0), 32'd42);
        chk("idx_seen0", 32'(seen0), 32'd1);
        chk("idx_cnt0",  32'(pos0),  32'd42);
        chk("idx_cnt1",  32'(pos1),  32'd0);
        chk("idx_pos1",  32'(ipos1), 32'd42);
        tick(1'b0, 1'b1, 1'b0);
        chk("idx_clr", 32'(seen0), 32'd0);
        z = 1'b0;
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        z = 1'b1;
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        chk("unarmed_seen", 32'(seen0), 32'd0);
        chk("unarmed_ipos", 32'(ipos0), 32'd42);

`ifdef QUAD_DECODER_PERIOD_EN
        do_reset(3'b000);
        move(1, 10);
        move(1, 10);
        chk("period10", 32'(per0), 32'd10);
        repeat (300) tick(1'b0, 1'b0, 1'b0);
        move(1, 2);
        chk("period_sat", 32'(per0), 32'd255);
`endif

        do_reset(3'b000);
        for (int i = 0; i < 600; i++) begin
            int sel;
            if ($urandom_range(0, 99) == 0) do_reset(3'($urandom_range(0, 7)));
            sel = $urandom_range(0, 9);
            if (sel < 4)      ph = (ph + 1) & 3;
            else if (sel < 7) ph = (ph + 3) & 3;
            else if (sel == 7) ph = (ph + 2) & 3;
            {a, b} = ab_of(ph);
            if ($urandom_range(0, 3) == 0) z = ~z;
            tick(1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 7) == 0),
                 1'($urandom_range(0, 7) == 0));
        end

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
